// File: rtl/jtdd_char_romrq.sv
// ---------------------------------------------------------------------------
// jtdd_char_romrq
//
// ROM request server for the character layer. The layer asks for single
// bytes (addr -> dout/data_ok); this block answers them from a small cache of
// 16-bit words and, on a miss, fetches the containing word from the SDRAM
// controller over a req/ack/dst handshake.
//
// Build option:
//   JTDD_CHAR_ROMRQ_CACHE2_EN  defined   -> two cache entries with a 1-bit
//                                           LRU victim pointer.
//                              undefined -> single cache entry.
//   Port list and timing are identical in both builds.
//
// Parameters:
//   AW           byte address width of the character ROM (word address AW-1)
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   downloading  ROM download in progress: invalidates cache, blocks fetches
//   addr         byte address from the character layer
//   dout         ROM byte for addr (meaningful when data_ok=1)
//   data_ok      addr hits a valid cached word (combinational)
//   sdram_addr   word address of the pending fetch (registered)
//   sdram_req    fetch request, held until acknowledged (registered)
//   sdram_ack    controller accepted the request
//   sdram_dst    data strobe, sdram_din valid this cycle
//   sdram_din    fetched word
// ---------------------------------------------------------------------------
module jtdd_char_romrq #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] addr,
    output logic [7:0]    dout,
    output logic          data_ok,
    output logic [AW-2:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_ack,
    input  logic          sdram_dst,
    input  logic [15:0]   sdram_din
);

`ifdef JTDD_CHAR_ROMRQ_CACHE2_EN
    localparam int NE = 2;
`else
    localparam int NE = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_DST = 2'd2
    } state_t;

    state_t        state_r;

    // Cache storage: one word per entry, tagged with its word address.
    logic [AW-2:0] tag_r   [NE];
    logic [15:0]   data_r  [NE];
    logic [NE-1:0] valid_r;

    logic [NE-1:0] hit_sel_s;   // one-hot(ish) set of entries matching addr
    logic          hit_s;
    logic [15:0]   word_s;      // word of the hitting entry, zero on a miss
    logic          fill_s;      // the fetched word is written this cycle
    logic [NE-1:0] fill_sel_s;  // entry receiving the fetched word

    // Tag compare against the current address; no registers on this path.
    // Entries holding the same tag always hold the same ROM word, so OR-ing
    // the matching words is safe.
    always_comb begin
        hit_sel_s = '0;
        word_s    = 16'h0000;
        for (int i = 0; i < NE; i++) begin
            hit_sel_s[i] = valid_r[i] && (tag_r[i] == addr[AW-1:1]);
            word_s       = word_s | ({16{hit_sel_s[i]}} & data_r[i]);
        end
        hit_s = |hit_sel_s;
    end

    // Byte select and hit flag presented to the character layer.
    always_comb begin
        data_ok = hit_s && !downloading;
        if (addr[0]) begin
            dout = word_s[15:8];
        end else begin
            dout = word_s[7:0];
        end
    end

    // A strobe only fills the cache while a fetch is actually outstanding;
    // the same-cycle ack+dst case fills straight from WAIT_ACK.
    always_comb begin
        fill_s = 1'b0;
        case (state_r)
            ST_WAIT_ACK: fill_s = sdram_ack && sdram_dst && !downloading;
            ST_WAIT_DST: fill_s = sdram_dst && !downloading;
            default:     fill_s = 1'b0;
        endcase
    end

`ifdef JTDD_CHAR_ROMRQ_CACHE2_EN
    logic victim_r;  // entry not used by the most recent hit or fill

    // Victim selection for the two-entry cache.
    always_comb begin
        if (victim_r) begin
            fill_sel_s = 2'b10;
        end else begin
            fill_sel_s = 2'b01;
        end
    end

    // 1-bit LRU: a fill makes the other entry the victim; a hit makes the
    // entry that was not hit the victim. Fills take precedence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            victim_r <= 1'b0;
        end else if (fill_s) begin
            victim_r <= ~victim_r;
        end else if (hit_s && !downloading) begin
            victim_r <= ~hit_sel_s[1];
        end else begin
            victim_r <= victim_r;
        end
    end
`else
    // Single-entry cache: every fill goes to entry 0.
    always_comb begin
        fill_sel_s = 1'b1;
    end
`endif

    // Fetch sequencer: issues one request per miss and tracks the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
        end else if (downloading) begin
            // Any fetch in flight is abandoned; the controller sees the
            // request withdrawn.
            state_r    <= ST_IDLE;
            sdram_req  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!hit_s) begin
                        sdram_addr <= addr[AW-1:1];
                        sdram_req  <= 1'b1;
                        state_r    <= ST_WAIT_ACK;
                    end else begin
                        sdram_req  <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (sdram_dst) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT_DST;
                        end
                    end else begin
                        sdram_req <= 1'b1;
                        state_r   <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_DST: begin
                    sdram_req <= 1'b0;
                    if (sdram_dst) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_DST;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Cache entries: cleared by download, written by an accepted strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            for (int i = 0; i < NE; i++) begin
                tag_r[i]  <= '0;
                data_r[i] <= 16'h0000;
            end
        end else if (downloading) begin
            valid_r <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (fill_s && fill_sel_s[i]) begin
                    tag_r[i]   <= sdram_addr;
                    data_r[i]  <= sdram_din;
                    valid_r[i] <= 1'b1;
                end else begin
                    tag_r[i]   <= tag_r[i];
                    data_r[i]  <= data_r[i];
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

endmodule

// File: doc/jtdd_char_romrq.md
# jtdd_char_romrq

ROM request server for the character layer: answers the layer's byte-wide `rom_addr`/`rom_data`/`rom_ok` lookups by fetching 16-bit words from the SDRAM controller over a req/ack/dst handshake. It sits between the character tile renderer and the SDRAM arbiter port reserved for the character ROM. It keeps the last fetched word(s) so that repeated and adjacent-byte lookups hit without SDRAM traffic.

## Interface
Parameters:
- `AW`, 15, byte address width of the character ROM; the SDRAM word address is `AW-1` bits.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `downloading`  in  1  ROM download in progress; invalidates the cache and blocks requests.
- `addr`  in  AW  byte address from the character layer, sampled every clock.
- `dout`  out  8  ROM byte for `addr`, valid when `data_ok`=1.
- `data_ok`  out  1  high when `addr` hits a valid cached word.
- `sdram_addr`  out  AW-1  word address of the pending fetch.
- `sdram_req`  out  1  fetch request; held until acknowledged.
- `sdram_ack`  in  1  controller accepted the request.
- `sdram_dst`  in  1  data strobe; `sdram_din` valid this cycle.
- `sdram_din`  in  16  fetched word.

## Operation
- Cache entry: `tag[AW-2:0]`, `valid`, `data[15:0]`. Hit = `valid && tag==addr[AW-1:1]`.
- Byte select: `addr[0]`=0 gives `data[7:0]`, 1 gives `data[15:8]`.
- `dout`/`data_ok` are combinational from the registered entry versus the current `addr`. There are no registers on the hit path.
- FSM states:
  - IDLE: on a miss with `downloading`=0, latch `sdram_addr<=addr[AW-1:1]`, set `sdram_req`=1, and go to WAIT_ACK.
  - WAIT_ACK: hold `sdram_req`=1 and `sdram_addr` stable.
    - On `sdram_ack`: clear `sdram_req` and go to WAIT_DST.
    - If `sdram_ack` and `sdram_dst` are both high in the same cycle: fill the entry and go straight to IDLE.
  - WAIT_DST: on `sdram_dst`, write `tag<=sdram_addr`, `data<=sdram_din`, `valid<=1`, then go to IDLE.
- An `addr` change while a fetch is in flight does not abort the fetch. The word still fills the entry. If the new `addr` then misses, a new fetch starts from IDLE on the next cycle.
- `sdram_dst` outside WAIT_DST (or WAIT_ACK+ack) is ignored.
- `downloading`=1 (synchronous effect):
  - all `valid` flags clear; FSM forced to IDLE; `sdram_req`=0.
  - `data_ok`=0 for as long as `downloading` stays high.
  - A strobe arriving during download is discarded.

## Timing
- Reset values: `sdram_req`=0, `sdram_addr`=0, FSM=IDLE, `valid`=0, `data`=0. This gives `dout`=0x00 and `data_ok`=0.
- Hit latency: 0 cycles. `data_ok` follows `addr` in the same cycle.
- Miss latency: `sdram_req` rises 1 cycle after the miss appears.
  - `data_ok` rises the cycle after `sdram_dst` is sampled.
  - With ack on cycle N and dst on cycle M, `data_ok` is high on cycle M+1.
- Back-to-back misses: minimum 1 idle cycle (IDLE) between the end of one fetch and the next `sdram_req`.
- `sdram_req` falls the cycle after `sdram_ack` is sampled high.
- `rst` asserted mid-fetch: all state returns to reset values immediately. The controller must tolerate a withdrawn request.

## Configuration
- `JTDD_CHAR_ROMRQ_CACHE2_EN` defined:
  - Two cache entries; a hit checks both.
  - A fill replaces the entry not used by the most recent hit or fill (1-bit LRU, reset to entry 0 as victim).
  - `downloading` clears both.
- Undefined: single entry as described above. Port list and timing are identical in both builds.

## Test plan
- Reset, then `addr`=0x0000: `data_ok`=0 and `dout`=0x00. One cycle later `sdram_req`=1 and `sdram_addr`=0x0000.
- Miss fill: `addr`=0x1235, ack after 3 cycles, dst with `sdram_din`=0xA55A. Then `data_ok`=1 and `dout`=0xA5; switching `addr` to 0x1234 gives `dout`=0x5A with no new `sdram_req`.
- Same-cycle ack+dst with `sdram_din`=0x1357 for `addr`=0x0002: FSM back to IDLE and `dout`=0x57 the next cycle; only one `sdram_req` pulse is seen.
- `addr` changes 0x0100 to 0x0300 during WAIT_DST: the fill stores tag 0x080 and `data_ok` stays 0. A second request with `sdram_addr`=0x180 follows after one IDLE cycle.
- `downloading` pulsed while in WAIT_ACK: `sdram_req` drops the next cycle and `data_ok`=0 for a previously cached address. After release, the same address refetches.
- With `JTDD_CHAR_ROMRQ_CACHE2_EN`: fill 0x0000, then fill 0x2000, then alternate the two addresses. No further requests occur. A third address 0x4000 evicts the less-recent entry.
